clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 10: tick_1hz pulses without a button edge before set mode is abandoned.
REQ-002 clk  input  1  sole clock, all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-004 tick_1hz  input  1  one-cycle pulse, once per second, from upstream prescaler.
REQ-005 btn_mode  input  1  debounced level, mode-advance button.
REQ-006 btn_inc  input  1  debounced level, increment button.
REQ-007 cur_hours  input  5  current hours from time-keeping datapath, 0-23.
REQ-008 cur_minutes  input  6  current minutes from time-keeping datapath, 0-59.
REQ-009 run_en  output  1  count enable to datapath; 1 only in RUN.
REQ-010 ld  output  1  one-cycle load strobe to datapath.
REQ-011 ld_hours  output  5  hours value to load; valid when ld=1.
REQ-012 ld_minutes  output  6  minutes value to load; valid when ld=1.
REQ-013 ld_seconds  output  6  seconds value to load; always 0.
REQ-014 mode  output  2  00=RUN, 01=SET_HR, 10=SET_MIN, 11=COMMIT.
REQ-015 blink  output  1  display blink phase for the field being edited.

Function
REQ-016 Button edges: internal registered copies of btn_mode/btn_inc; edge = btn & ~prev; one edge per press regardless of hold length.
REQ-017 States: RUN, SET_HR, SET_MIN, COMMIT; mode output equals state encoding, registered.
REQ-018 RUN: run_en=1, ld=0, blink=0; mode edge -> SET_HR, capturing cur_hours into edit_hr and cur_minutes into edit_min in the same cycle.
REQ-019 SET_HR: run_en=0; inc edge -> edit_hr = (edit_hr==23) ? 0 : edit_hr+1; mode edge -> SET_MIN.
REQ-020 SET_MIN: run_en=0; inc edge -> edit_min = (edit_min==59) ? 0 : edit_min+1; mode edge -> COMMIT.
REQ-021 COMMIT: lasts exactly one cycle; ld=1, ld_hours=edit_hr, ld_minutes=edit_min, ld_seconds=0, run_en=0; next state RUN unconditionally.
REQ-022 ld/ld_* and run_en are registered outputs; ld is asserted in the cycle mode==11 and in no other cycle.
REQ-023 ld_hours/ld_minutes continuously reflect edit_hr/edit_min (not gated to zero outside COMMIT).
REQ-024 Simultaneous mode and inc edges in the same cycle: mode edge wins, inc edge discarded.
REQ-025 Edges in COMMIT are discarded; inc edges in RUN are discarded.
REQ-026 Timeout: counter cleared on entry to SET_HR and on every button edge in SET_HR/SET_MIN; increments on tick_1hz in SET_HR/SET_MIN; on reaching TIMEOUT_TICKS -> RUN with no ld pulse (edit abandoned, datapath untouched).
REQ-027 If a button edge and the terminal tick coincide, the edge is processed and the timeout counter clears (no abandon).
REQ-028 blink: toggles on each tick_1hz in SET_HR/SET_MIN; forced to 1 on entry to SET_HR and on SET_HR->SET_MIN; forced to 0 in RUN/COMMIT.
REQ-029 tick_1hz has no effect in RUN (datapath counts from its own enable).

Reset
REQ-030 rst=0 at a clock edge: state=RUN, run_en=1, ld=0, ld_hours=0, ld_minutes=0, ld_seconds=0, mode=00, blink=0, edit_hr=0, edit_min=0, timeout counter=0.
REQ-031 Button prev registers reset to 1, so a button held through reset release generates no edge.
REQ-032 Reset mid-edit (any state) abandons the edit with no ld pulse; reset dominates all other inputs.

Verification
REQ-033 Reset then idle 5 cycles -> mode=00, run_en=1, ld=0, all ld_* = 0, blink=0.
REQ-034 cur=10:15; mode press, 3 inc, mode, 50 inc, mode -> single ld cycle with ld_hours=13, ld_minutes=5, ld_seconds=0, then mode=00, run_en=1.
REQ-035 cur=23:59; mode, inc, mode, inc, mode -> ld_hours=0, ld_minutes=0 (wrap both fields).
REQ-036 Enter SET_HR, apply 10 tick_1hz with no buttons -> return to RUN on 10th tick, ld never asserted, blink toggled 0/1 each tick meanwhile.
REQ-037 In SET_HR assert btn_mode and btn_inc rising in the same cycle -> mode=10, edit_hr unchanged; btn_inc held 20 cycles -> exactly one increment.
REQ-038 Drive rst=0 while in SET_MIN with btn_mode held -> RUN, ld=0; release rst with btn_mode still high -> no transition until button released and pressed again.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Set-mode controller for a 24h clock: button edge detect, edit FSM,
// inactivity timeout and one-cycle load strobe toward the time datapath.
module clock_set_ctrl #(
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       run_en,
  output logic       ld,
  output logic [4:0] ld_hours,
  output logic [5:0] ld_minutes,
  output logic [5:0] ld_seconds,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    COMMIT  = 2'b11
  } state_t;

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_TICKS - 1);

  state_t        state;
  state_t        nstate;
  logic          mode_prev;
  logic          inc_prev;
  logic          mode_e;
  logic          inc_e;
  logic          editing;
  logic          expire;
  logic [4:0]    edit_hr;
  logic [5:0]    edit_min;
  logic [TW-1:0] tcnt;
  logic          run_en_d;
  logic          ld_d;
  logic          blink_d;

  assign mode_e  = btn_mode & ~mode_prev;
  assign inc_e   = btn_inc & ~inc_prev;
  assign editing = (state == SET_HR) || (state == SET_MIN);

  // Any button edge restarts the idle window, even on the terminal tick.
  assign expire = editing & tick_1hz & ~mode_e & ~inc_e
                & (tcnt == T_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      RUN:     if (mode_e) nstate = SET_HR;
      SET_HR: begin
        if (mode_e)      nstate = SET_MIN;
        else if (expire) nstate = RUN;
      end
      SET_MIN: begin
        if (mode_e)      nstate = COMMIT;
        else if (expire) nstate = RUN;
      end
      COMMIT:  nstate = RUN;
      default: nstate = RUN;
    endcase
  end

  always_comb begin
    run_en_d = (nstate == RUN);
    ld_d     = (nstate == COMMIT);
    blink_d  = 1'b0;
    if (nstate == SET_HR || nstate == SET_MIN) begin
      if (nstate != state)  blink_d = 1'b1;
      else if (tick_1hz)    blink_d = ~blink;
      else                  blink_d = blink;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
      run_en    <= 1'b1;
      ld        <= 1'b0;
      blink     <= 1'b0;
      edit_hr   <= '0;
      edit_min  <= '0;
      tcnt      <= '0;
    end else begin
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
      run_en    <= run_en_d;
      ld        <= ld_d;
      blink     <= blink_d;
      unique case (state)
        RUN: if (mode_e) begin
          edit_hr  <= cur_hours;
          edit_min <= cur_minutes;
        end
        SET_HR: if (inc_e && !mode_e) begin
          edit_hr <= (edit_hr == 5'd23) ? 5'd0 : edit_hr + 5'd1;
        end
        SET_MIN: if (inc_e && !mode_e) begin
          edit_min <= (edit_min == 6'd59) ? 6'd0 : edit_min + 6'd1;
        end
        default: ;
      endcase
      if (!editing || mode_e || inc_e || expire) tcnt <= '0;
      else if (tick_1hz)                         tcnt <= tcnt + 1'b1;
    end
  end

  assign mode       = state;
  assign ld_hours   = edit_hr;
  assign ld_minutes = edit_min;
  assign ld_seconds = 6'd0;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with hand-computed expectations.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       run_en;
  logic       ld;
  logic [4:0] ld_hours;
  logic [5:0] ld_minutes;
  logic [5:0] ld_seconds;
  logic [1:0] mode;
  logic       blink;

  int total = 0;
  int bad   = 0;
  int ld_cnt = 0;
  int snap;

  clock_set_ctrl #(.TIMEOUT_TICKS(10)) dut (
    .clk(clk),
    .rst(rst),
    .tick_1hz(tick_1hz),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
    .cur_hours(cur_hours),
    .cur_minutes(cur_minutes),
    .run_en(run_en),
    .ld(ld),
    .ld_hours(ld_hours),
    .ld_minutes(ld_minutes),
    .ld_seconds(ld_seconds),
    .mode(mode),
    .blink(blink)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ld) ld_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    cyc();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cyc();
  endtask

  initial begin
    rst         = 1'b0;
    tick_1hz    = 1'b0;
    btn_mode    = 1'b0;
    btn_inc     = 1'b0;
    cur_hours   = 5'd10;
    cur_minutes = 6'd15;
    cyc(2);
    chk("rst_mode", mode, 0);
    chk("rst_run_en", run_en, 1);
    rst = 1'b1;
    cyc(5);
    chk("idle_mode", mode, 0);
    chk("idle_run_en", run_en, 1);
    chk("idle_ld", ld, 0);
    chk("idle_ld_h", ld_hours, 0);
    chk("idle_ld_m", ld_minutes, 0);
    chk("idle_ld_s", ld_seconds, 0);
    chk("idle_blink", blink, 0);

    // 10:15 -> 13:05
    press(1, 0);
    chk("e_mode", mode, 1);
    chk("e_run_en", run_en, 0);
    chk("e_blink", blink, 1);
    chk("e_cap_h", ld_hours, 10);
    chk("e_cap_m", ld_minutes, 15);
    repeat (3) press(0, 1);
    chk("e_hr13", ld_hours, 13);
    press(1, 0);
    chk("e_setmin", mode, 2);
    chk("e_blink2", blink, 1);
    repeat (50) press(0, 1);
    chk("e_min5", ld_minutes, 5);
    snap = ld_cnt;
    btn_mode = 1'b1;
    cyc();
    chk("c_mode", mode, 3);
    chk("c_ld", ld, 1);
    chk("c_ld_h", ld_hours, 13);
    chk("c_ld_m", ld_minutes, 5);
    chk("c_ld_s", ld_seconds, 0);
    chk("c_run_en", run_en, 0);
    chk("c_blink", blink, 0);
    btn_mode = 1'b0;
    cyc();
    chk("c_back_mode", mode, 0);
    chk("c_back_run", run_en, 1);
    chk("c_back_ld", ld, 0);
    cyc(3);
    chk("c_one_ld", ld_cnt - snap, 1);
    press(0, 1);
    chk("run_inc_ign", mode, 0);

    // 23:59 wraps to 00:00
    cur_hours   = 5'd23;
    cur_minutes = 6'd59;
    press(1, 0);
    press(0, 1);
    chk("w_hr0", ld_hours, 0);
    press(1, 0);
    press(0, 1);
    btn_mode = 1'b1;
    cyc();
    chk("w_ld", ld, 1);
    chk("w_ld_h", ld_hours, 0);
    chk("w_ld_m", ld_minutes, 0);
    btn_mode = 1'b0;
    cyc(2);

    // abandon on the tenth idle tick
    cur_hours   = 5'd5;
    cur_minutes = 6'd30;
    snap = ld_cnt;
    press(1, 0);
    chk("t_mode", mode, 1);
    for (int k = 1; k <= 10; k++) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      if (k < 10) begin
        chk($sformatf("t_mode%0d", k), mode, 1);
        chk($sformatf("t_blink%0d", k), blink, (k % 2 == 0));
      end else begin
        chk("t_exit_mode", mode, 0);
        chk("t_exit_run", run_en, 1);
        chk("t_exit_blink", blink, 0);
      end
      cyc();
    end
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    cyc();
    chk("t_run_tick", mode, 0);
    chk("t_no_ld", ld_cnt - snap, 0);

    // simultaneous edges, then long inc hold
    press(1, 0);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    cyc();
    chk("s_mode", mode, 2);
    chk("s_hr", ld_hours, 5);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cyc();
    btn_inc = 1'b1;
    cyc(20);
    btn_inc = 1'b0;
    cyc();
    chk("s_hold_m", ld_minutes, 31);
    chk("s_hold_mode", mode, 2);

    // reset mid-edit with mode held through release
    snap = ld_cnt;
    btn_mode = 1'b1;
    rst = 1'b0;
    cyc();
    chk("r_mode", mode, 0);
    chk("r_ld", ld, 0);
    chk("r_run_en", run_en, 1);
    chk("r_ld_h", ld_hours, 0);
    chk("r_ld_m", ld_minutes, 0);
    cyc();
    rst = 1'b1;
    cyc(3);
    chk("r_held", mode, 0);
    chk("r_no_ld", ld_cnt - snap, 0);
    btn_mode = 1'b0;
    cyc();
    chk("r_release", mode, 0);
    btn_mode = 1'b1;
    cyc();
    chk("r_repress", mode, 1);
    btn_mode = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
